// File: rtl/result_display.sv
// Result display: captures an 8-bit result, converts it to BCD with an
// iterative double-dabble FSM and scans it onto a 4-digit 7-seg display.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   result       in   [7:0] unsigned value to display
//   result_valid in   1-cycle strobe qualifying result
//   busy         out  conversion in progress
//   bcd          out  [11:0] last completed {hundreds,tens,ones}
//   an           out  [3:0] digit enables, active-low, an[0] = ones
//   seg          out  [6:0] segments {g,f,e,d,c,b,a}, active-low
module result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  result,
    input  logic        result_valid,
    output logic        busy,
    output logic [11:0] bcd,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] sr_q, sr_d;
    logic [2:0]  iter_q, iter_d;
    logic [7:0]  pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [11:0] bcd_q, bcd_d;
    logic        busy_q, busy_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    // One double-dabble step: bump any BCD nibble >= 5 by 3, then shift.
    function automatic logic [19:0] dabble(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (result_valid) state_d = S_CONVERT;
            S_CONVERT: if (iter_q == 3'd7) state_d = S_DONE;
            S_DONE:    state_d = (pend_vld_q || result_valid) ? S_CONVERT
                                                              : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs and conversion datapath
    always_comb begin
        sr_d       = sr_q;
        iter_d     = iter_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        bcd_d      = bcd_q;
        busy_d     = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (result_valid) begin
                    sr_d   = {12'h000, result};
                    iter_d = 3'd0;
                end
            end
            S_CONVERT: begin
                sr_d   = dabble(sr_q);
                iter_d = iter_q + 3'd1;
                if (result_valid) begin
                    pend_d     = result;
                    pend_vld_d = 1'b1;
                end
            end
            S_DONE: begin
                bcd_d  = sr_q[19:8];
                iter_d = 3'd0;
                if (pend_vld_q) begin
                    // Start on the buffered value; a strobe this cycle
                    // becomes the new pending entry.
                    sr_d       = {12'h000, pend_q};
                    pend_vld_d = result_valid;
                    if (result_valid) pend_d = result;
                end else if (result_valid) begin
                    // Empty buffer: write-then-load collapses to a direct load.
                    sr_d = {12'h000, result};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q       <= '0;
            iter_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            iter_q     <= iter_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            bcd_q      <= bcd_d;
            busy_q     <= busy_d;
        end
    end

    // Display scan
    always_comb begin
        logic [3:0] nib;
        logic       blank;
        logic       wrap;
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        digit_d = wrap ? digit_q + 2'd1 : digit_q;
        an_d    = ~(4'b0001 << digit_q);
        nib     = 4'd0;
        blank   = 1'b1;
        unique case (digit_q)
            2'd0: begin
                nib   = bcd_q[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                nib   = bcd_q[7:4];
                blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
            end
            2'd2: begin
                nib   = bcd_q[11:8];
                blank = (bcd_q[11:8] == 4'd0);
            end
            default: begin
                nib   = 4'd0;
                blank = 1'b1;
            end
        endcase
        seg_d = blank ? SEG_BLANK : seg_of(nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            digit_q <= '0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign busy = busy_q;
    assign bcd  = bcd_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_result_display.sv
// Testbench for result_display: randomized results and mid-conversion
// strobes checked against an arithmetic reference model.
module tb_result_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  result = 8'd0;
    logic        result_valid = 1'b0;
    logic        busy;
    logic [11:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_chk  = 0;
    int n_fail = 0;
    int k      = 0;
    int cur_val = 0;

    logic [6:0] seg_tab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    result_display #(.REFRESH_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .bcd          (bcd),
        .an           (an),
        .seg          (seg)
    );

    always #5 clk = ~clk;

    // Edges since reset released
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [6:0] ref_seg(input int idx, input int v);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        case (idx)
            0:       return seg_tab[o];
            1:       return (h == 0 && t == 0) ? 7'b1111111 : seg_tab[t];
            2:       return (h == 0) ? 7'b1111111 : seg_tab[h];
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_chk(input string tag, input int n);
        int idx;
        logic [3:0] ea;
        logic [6:0] es;
        for (int i = 0; i < n; i++) begin
            tick();
            idx = ((k - 1) / DIV) % 4;
            ea  = ~(4'b0001 << idx);
            es  = ref_seg(idx, cur_val);
            chk({tag, "_an"}, 32'(an), 32'(ea));
            chk({tag, "_seg"}, 32'(seg), 32'(es));
        end
    endtask

    // Strobe v0; optionally strobe x1 / x2 two and four cycles later.
    task automatic xact(input int v0, input int nx, input int x1,
                        input int x2);
        int  last;
        int  bh;
        bit  fell;
        last = (nx == 0) ? v0 : (nx == 1) ? x1 : x2;
        result = 8'(v0);
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        chk("busy_lag", 32'(busy), 32'd0);
        bh = 0;
        fell = 1'b0;
        for (int c = 1; c <= 40 && !fell; c++) begin
            if (c == 2 && nx >= 1) begin
                result = 8'(x1);
                result_valid = 1'b1;
            end
            if (c == 4 && nx >= 2) begin
                result = 8'(x2);
                result_valid = 1'b1;
            end
            tick();
            result_valid = 1'b0;
            if (busy) bh++;
            else      fell = 1'b1;
            if (c == 9)
                chk("bcd_first", 32'(bcd), 32'(ref_bcd(v0)));
            if (c == 17 && nx > 0)
                chk("bcd_hold", 32'(bcd), 32'(ref_bcd(v0)));
        end
        chk("busy_len", 32'(bh), (nx > 0) ? 32'd18 : 32'd9);
        chk("bcd_final", 32'(bcd), 32'(ref_bcd(last)));
        cur_val = last;
    endtask

    initial begin
        int v, nx, x1, x2;

        rst = 1'b1;
        tick();
        tick();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_an", 32'(an), 32'hE);
        chk("rel_seg", 32'(seg), 32'h40);
        scan_chk("zero", 8);

        xact(3, 0, 0, 0);
        scan_chk("d3", 16);
        xact(255, 0, 0, 0);
        scan_chk("d255", 20);
        xact(5, 2, 7, 9);
        scan_chk("d9", 8);
        xact(42, 0, 0, 0);
        scan_chk("d42", 16);
        xact(0, 0, 0, 0);
        scan_chk("d0", 16);
        xact(100, 0, 0, 0);
        scan_chk("d100", 16);
        xact(10, 1, 99, 0);
        scan_chk("d99", 16);

        for (int i = 0; i < 10; i++) begin
            v  = int'($urandom_range(0, 255));
            nx = int'($urandom_range(0, 2));
            x1 = int'($urandom_range(0, 255));
            x2 = int'($urandom_range(0, 255));
            xact(v, nx, x1, x2);
            scan_chk("rnd", 16);
        end

        // Reset on the 4th conversion cycle with a value pending.
        result = 8'd200;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        tick();
        result = 8'd77;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bcd", 32'(bcd), 32'd0);
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        rst = 1'b0;
        cur_val = 0;
        tick();
        chk("post_rst_an", 32'(an), 32'hE);
        chk("post_rst_seg", 32'(seg), 32'h40);
        for (int i = 0; i < 24; i++) begin
            tick();
            chk("post_rst_idle", 32'(busy), 32'd0);
            chk("post_rst_bcd", 32'(bcd), 32'd0);
        end
        scan_chk("post_rst", 16);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
